// File: rtl/nrs_cinit_gen_if.sv
// Request/result bundle between the NRS value generator and the cinit engine.
interface nrs_cinit_gen_if #(
  parameter int WIDTH   = 18,
  parameter int WIDTH_B = 9
);
  logic                 run;
  logic [WIDTH_B-1:0]   N_cell_ID;
  logic [4:0]           slot;
  logic [WIDTH+9:0]     cinit;
  logic                 valid;

  modport master (output run, N_cell_ID, slot, input cinit, valid);
  modport slave  (input run, N_cell_ID, slot, output cinit, valid);
endinterface

// File: rtl/nrs_cinit_gen_top.sv
// NB-IoT NRS Gold-sequence seed: cinit = 2^10*A*B + B, A = 7*(ns+1)+l+1, B = 2*N_cell_ID+1.
// Runs alternate l=5 / l=6; a serial radix-4 shift-add multiplier gives latency 6 (l=5) or 7 (l=6).
module nrs_cinit_gen_top #(
  parameter int WIDTH   = 18,
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 9
) (
  input  logic               clk,
  input  logic               rst,
  nrs_cinit_gen_if.slave     bus
);

  localparam int CW    = WIDTH + 10;
  localparam int STEPS = (WIDTH_A + 1) / 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_MUL   = 3'd2,
    S_PAD   = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               toggle_q, toggle_d;
  logic               l6_q, l6_d;
  logic [WIDTH_B-1:0] n_q, n_d;
  logic [4:0]         ns_q, ns_d;
  logic [WIDTH_A-1:0] a_q, a_d;
  logic [WIDTH_B:0]   b_q, b_d;
  logic [WIDTH-1:0]   bsh_q, bsh_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [2:0]         step_q, step_d;
  logic [CW-1:0]      cinit_q, cinit_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   pp0_s, pp1_s;

  // Two partial products per step: bits 0 and 1 of the remaining multiplier.
  always_comb begin
    pp0_s = a_q[0] ? bsh_q : {WIDTH{1'b0}};
    pp1_s = a_q[1] ? {bsh_q[WIDTH-2:0], 1'b0} : {WIDTH{1'b0}};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    toggle_d = toggle_q;
    l6_d     = l6_q;
    n_d      = n_q;
    ns_d     = ns_q;
    a_d      = a_q;
    b_d      = b_q;
    bsh_d    = bsh_q;
    acc_d    = acc_q;
    step_d   = step_q;
    cinit_d  = cinit_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          n_d      = bus.N_cell_ID;
          ns_d     = bus.slot;
          l6_d     = toggle_q;
          toggle_d = ~toggle_q;
          state_d  = S_PREP;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_PREP: begin
        // 7*(ns+1)+l+1 folds to 7*ns+13 (l=5) or 7*ns+14 (l=6).
        a_d     = WIDTH_A'(ns_q) * WIDTH_A'(3'd7)
                + (l6_q ? WIDTH_A'(4'd14) : WIDTH_A'(4'd13));
        b_d     = {n_q, 1'b1};
        bsh_d   = WIDTH'({n_q, 1'b1});
        acc_d   = {WIDTH{1'b0}};
        step_d  = 3'd0;
        state_d = S_MUL;
      end
      S_MUL: begin
        acc_d  = acc_q + pp0_s + pp1_s;
        bsh_d  = {bsh_q[WIDTH-3:0], 2'b00};
        a_d    = {2'b00, a_q[WIDTH_A-1:2]};
        step_d = step_q + 3'd1;
        if (step_q == 3'(STEPS - 1)) begin
          state_d = l6_q ? S_PAD : S_WRITE;
        end else begin
          state_d = S_MUL;
        end
      end
      S_PAD: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        cinit_d = {acc_q, 10'b0} + CW'(b_q);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run and rewinds l to 5.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      toggle_q <= 1'b0;
      l6_q     <= 1'b0;
      n_q      <= {WIDTH_B{1'b0}};
      ns_q     <= 5'd0;
      a_q      <= {WIDTH_A{1'b0}};
      b_q      <= {(WIDTH_B+1){1'b0}};
      bsh_q    <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      step_q   <= 3'd0;
      cinit_q  <= {CW{1'b0}};
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      toggle_q <= toggle_d;
      l6_q     <= l6_d;
      n_q      <= n_d;
      ns_q     <= ns_d;
      a_q      <= a_d;
      b_q      <= b_d;
      bsh_q    <= bsh_d;
      acc_q    <= acc_d;
      step_q   <= step_d;
      cinit_q  <= cinit_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.cinit = cinit_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_nrs_cinit_gen_top.sv
// Directed plus randomized bench for nrs_cinit_gen_top against a formula-level reference.
module tb_nrs_cinit_gen_top;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  bit   model_l6 = 1'b0;
  logic [63:0] model_cinit = 64'd0;

  nrs_cinit_gen_if #(.WIDTH(18), .WIDTH_B(9)) bus ();

  nrs_cinit_gen_top #(.WIDTH(18), .WIDTH_A(8), .WIDTH_B(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_cinit(input int n, input int ns, input int l);
    longint a, b, p;
    a = (7 * (ns + 1) + l + 1) % 256;
    b = (2 * n + 1) % 1024;
    p = (a * b) % 262144;
    return 64'(p * 1024 + b);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic do_run(input int n, input int ns, input bit extra);
    int l;
    int lat;
    bit got;
    logic [63:0] exp;
    l = model_l6 ? 6 : 5;
    model_l6 = ~model_l6;
    exp = ref_cinit(n, ns, l);
    @(negedge clk);
    bus.run = 1'b1;
    bus.N_cell_ID = 9'(n);
    bus.slot = 5'(ns);
    @(posedge clk);
    #1 bus.run = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1 lat++;
      if (extra && lat == 1) begin
        bus.run = 1'b1;
        bus.N_cell_ID = 9'($urandom);
        bus.slot = 5'($urandom);
      end else begin
        bus.run = 1'b0;
      end
      if (bus.valid === 1'b1) got = 1'b1;
      else check("hold_busy", 64'(bus.cinit), model_cinit);
    end
    check("latency", 64'(lat), (l == 5) ? 64'd6 : 64'd7);
    check("cinit", 64'(bus.cinit), exp);
    model_cinit = exp;
    @(posedge clk);
    #1 check("valid_drop", 64'(bus.valid), 64'd0);
    check("cinit_keep", 64'(bus.cinit), exp);
  endtask

  initial begin
    bus.run = 1'b0;
    bus.N_cell_ID = 9'd0;
    bus.slot = 5'd0;
    #2 rst = 1'b0;

    // Reset dominance: run pulsed while reset is held.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.run = (i >= 5 && i < 10) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    bus.run = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 check("rst_valid", 64'(bus.valid), 64'd0);
      check("rst_cinit", 64'(bus.cinit), 64'd0);
    end

    do_run(0, 0, 1'b0);
    check("n0_l5_const", model_cinit, 64'd13313);
    do_run(0, 0, 1'b0);
    check("n0_l6_const", model_cinit, 64'd14337);
    do_run(1, 1, 1'b0);
    check("n1_const", 64'(bus.cinit), 64'd61443);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("idle_hold", 64'(bus.cinit), 64'd61443);
      check("idle_valid", 64'(bus.valid), 64'd0);
    end
    do_run(503, 19, 1'b0);
    check("max_const", 64'(bus.cinit), 64'd151582703);

    // Extra run pulse at E+2 must not restart or toggle.
    do_run(17, 4, 1'b1);
    do_run(17, 4, 1'b0);

    for (int i = 0; i < 150; i++) begin
      int k;
      k = $urandom_range(0, 17);
      do_run($urandom_range(0, 503), (k < 10) ? k : k + 2, 1'b0);
    end

    do_run(511, 31, 1'b0);
    do_run(510, 20, 1'b0);
    do_run(504, 25, 1'b0);
    do_run(509, 31, 1'b0);

    // Reset in the middle of a computation.
    @(negedge clk);
    bus.run = 1'b1;
    bus.N_cell_ID = 9'd7;
    bus.slot = 5'd3;
    @(posedge clk);
    #1 bus.run = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_cinit", 64'(bus.cinit), 64'd0);
    check("midrst_valid", 64'(bus.valid), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_l6 = 1'b0;
    model_cinit = 64'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 check("post_rst_valid", 64'(bus.valid), 64'd0);
      check("post_rst_cinit", 64'(bus.cinit), 64'd0);
    end
    do_run(100, 8, 1'b0);
    do_run(100, 8, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
